instruction_fetch_unit: RTL and testbench

Program-counter and fetch stage of the MiniALU core. Drives the address of the combinational instruction ROM and registers the returned 28-bit word for the decode/execute stage. Handles downstream stalls and branch redirects. Folds unconditional jumps locally so they cost no execute cycle.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 78 +++++++
 tb/tb_instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, stall and redirect inputs,
// registered instruction, its PC, valid flag and stall counter.
interface instruction_fetch_unit_if;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;
  logic [15:0] oStallCount;

  modport master (
    output oAddress,
    output oInstruction,
    output oPC,
    output oValid,
    output oStallCount,
    input  iInstruction,
    input  iStall,
    input  iBranchTaken,
    input  iBranchTarget
  );

  modport slave (
    input  oAddress,
    input  oInstruction,
    input  oPC,
    input  oValid,
    input  oStallCount,
    output iInstruction,
    output iStall,
    output iBranchTaken,
    output iBranchTarget
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC and fetch stage: drives ROM address, registers the word,
// handles stalls, branch redirects and folds unconditional jumps.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter logic [3:0]  JMP_OPCODE = 4'd7,
  parameter logic [27:0] NOP_WORD   = 28'h0000000
) (
  input logic                   Clock,
  input logic                   Reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    START,
    RUN,
    HOLD
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] opc;
  logic [15:0] cnt;
  logic [27:0] ins;
  logic        val;

  logic        jmp;
  logic [15:0] jtgt;

  assign jmp  = bus.iInstruction[27:24] == JMP_OPCODE;
  assign jtgt = {8'h00, bus.iInstruction[23:16]};

  assign bus.oAddress     = pc;
  assign bus.oInstruction = ins;
  assign bus.oPC          = opc;
  assign bus.oValid       = val;
  assign bus.oStallCount  = cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= START;
      pc    <= RESET_PC;
      opc   <= 16'h0000;
      ins   <= NOP_WORD;
      val   <= 1'b0;
      cnt   <= 16'h0000;
    end else if (bus.iBranchTaken) begin
      state <= RUN;
      pc    <= bus.iBranchTarget;
      ins   <= NOP_WORD;
      val   <= 1'b0;
    end else begin
      unique case (state)
        START: state <= RUN;
        RUN, HOLD: begin
          if (bus.iStall) begin
            state <= HOLD;
            if (cnt != 16'hFFFF)
              cnt <= cnt + 16'd1;
          end else if (jmp) begin
            // jump folded here; execute never sees it
            state <= RUN;
            pc    <= jtgt;
            ins   <= NOP_WORD;
            val   <= 1'b0;
          end else begin
            state <= RUN;
            ins   <= bus.iInstruction;
            opc   <= pc;
            val   <= 1'b1;
            pc    <= pc + 16'd1;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus
// random stall/branch/reset traffic against a reference model.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RPC = 16'd0;
  localparam logic [27:0] NOP = 28'h0000000;

  logic Clock;
  logic Reset;
  logic stall;
  logic br;
  logic [15:0] tgt;

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit #(
    .RESET_PC   (RPC),
    .JMP_OPCODE (4'd7),
    .NOP_WORD   (NOP)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifc.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  bit mode = 0;
  int rev = 0;
  logic [7:0] jmap [logic [15:0]];

  function automatic logic [27:0] rom(
    input logic [15:0] a, input int r);
    logic [3:0] op;
    if (r < 0) return NOP;
    if (jmap.exists(a))
      return {4'd7, jmap[a], 16'h0000};
    if (!mode) return {12'h000, a};
    op = (a[3:0] == 4'd7) ? 4'd8 : a[3:0];
    return {op, a[15:8] ^ a[7:0], a};
  endfunction

  assign ifc.iInstruction  = rom(ifc.oAddress, rev);
  assign ifc.iStall        = stall;
  assign ifc.iBranchTaken  = br;
  assign ifc.iBranchTarget = tgt;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // reference model
  logic [15:0] m_pc, m_opc, m_cnt;
  logic [27:0] m_ins;
  logic        m_val, m_fresh;

  always @(posedge Clock) begin
    automatic logic [27:0] w = rom(m_pc, rev);
    if (Reset) begin
      m_pc <= RPC; m_opc <= 16'h0; m_ins <= NOP;
      m_val <= 1'b0; m_cnt <= 16'h0; m_fresh <= 1'b1;
    end else if (br) begin
      m_pc <= tgt; m_ins <= NOP; m_val <= 1'b0;
      m_fresh <= 1'b0;
    end else if (m_fresh) begin
      m_fresh <= 1'b0;
    end else if (stall) begin
      m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end else if (w[27:24] == 4'd7) begin
      m_pc <= {8'h00, w[23:16]}; m_ins <= NOP; m_val <= 1'b0;
    end else begin
      m_ins <= w; m_opc <= m_pc; m_val <= 1'b1;
      m_pc <= m_pc + 16'd1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("m_addr", 32'(ifc.oAddress), 32'(m_pc));
      chk("m_ins", 32'(ifc.oInstruction), 32'(m_ins));
      chk("m_pc", 32'(ifc.oPC), 32'(m_opc));
      chk("m_val", 32'(ifc.oValid), 32'(m_val));
      chk("m_cnt", 32'(ifc.oStallCount), 32'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic branch(input logic [15:0] t);
    br = 1'b1; tgt = t;
    step();
    br = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; stall = 1'b0; br = 1'b0; tgt = 16'h0;
    step();
    cmp_en = 1;
    step();
    chk("rst_addr", 32'(ifc.oAddress), 32'(RPC));
    chk("rst_ins", 32'(ifc.oInstruction), 32'(NOP));
    chk("rst_pc", 32'(ifc.oPC), 32'h0);
    chk("rst_val", 32'(ifc.oValid), 32'h0);
    chk("rst_cnt", 32'(ifc.oStallCount), 32'h0);

    Reset = 1'b0;
    step();
    chk("start_val", 32'(ifc.oValid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("seq_pc", 32'(ifc.oPC), 32'(k));
      chk("seq_val", 32'(ifc.oValid), 32'h1);
    end

    stall = 1'b1;
    step(3);
    chk("hold_pc", 32'(ifc.oPC), 32'h5);
    chk("hold_ins", 32'(ifc.oInstruction), 32'h5);
    chk("hold_addr", 32'(ifc.oAddress), 32'h6);
    chk("hold_cnt", 32'(ifc.oStallCount), 32'h3);
    stall = 1'b0;
    step();
    chk("unhold_pc", 32'(ifc.oPC), 32'h6);

    stall = 1'b1;
    step();
    branch(16'h0040);
    chk("br_val", 32'(ifc.oValid), 32'h0);
    chk("br_cnt", 32'(ifc.oStallCount), 32'h4);
    stall = 1'b0;
    step();
    chk("br_pc", 32'(ifc.oPC), 32'h40);
    chk("br_val2", 32'(ifc.oValid), 32'h1);

    jmap[16'd14] = 8'd2; rev++;
    branch(16'd12);
    step(2);
    chk("pre_jmp", 32'(ifc.oPC), 32'd13);
    step();
    chk("jmp_val", 32'(ifc.oValid), 32'h0);
    chk("jmp_addr", 32'(ifc.oAddress), 32'h2);
    step();
    chk("jmp_pc", 32'(ifc.oPC), 32'h2);
    chk("jmp_val2", 32'(ifc.oValid), 32'h1);
    jmap.delete(16'd14); rev++;

    branch(16'hFFFF);
    step();
    chk("wrap_pc0", 32'(ifc.oPC), 32'hFFFF);
    step();
    chk("wrap_pc1", 32'(ifc.oPC), 32'h0);
    chk("wrap_val", 32'(ifc.oValid), 32'h1);

    branch(16'h0080);
    Reset = 1'b1;
    step();
    chk("rb_addr", 32'(ifc.oAddress), 32'(RPC));
    chk("rb_val", 32'(ifc.oValid), 32'h0);
    Reset = 1'b0;
    step();
    chk("rb_start", 32'(ifc.oValid), 32'h0);
    step();
    chk("rb_pc", 32'(ifc.oPC), 32'(RPC));

    stall = 1'b1;
    step(65540);
    chk("sat_cnt", 32'(ifc.oStallCount), 32'hFFFF);
    stall = 1'b0;

    mode = 1; Reset = 1'b1;
    for (int i = 0; i < 10; i++)
      jmap[16'($urandom_range(0, 255))] = 8'($urandom);
    rev++;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 7) == 0)
            ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
            : 16'($urandom_range(0, 255));
      Reset = ($urandom_range(0, 199) == 0);
      step();
    end
    Reset = 1'b0; br = 1'b0; stall = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
